// File: rtl/axi_bram_log_drain_ctrl.sv
// Drain controller for one AXI BRAM logger: gates logging, streams the whole
// log array out over valid/ready, then pulses clear and waits out the sweep.
module axi_bram_log_drain_ctrl #(
  parameter int NUM_SER_BRAMS = 12,
  parameter int NUM_PAR_BRAMS = 3,
  parameter int CLEAR_WAIT    = 1024*NUM_SER_BRAMS+4
) (
  input  logic        Clk_CI,
  input  logic        Rst_RI,
  input  logic        Start_SI,
  input  logic        AutoDrain_SI,
  input  logic        Abort_SI,
  input  logic        LogFull_SI,
  output logic        LogEn_SO,
  output logic        LogClear_SO,
  output logic        BramEn_SO,
  output logic [31:0] BramAddr_DO,
  input  logic [31:0] BramRd_DI,
  output logic        OutValid_SO,
  input  logic        OutReady_SI,
  output logic [31:0] OutData_DO,
  output logic        OutLast_SO,
  output logic        Busy_SO,
  output logic        Done_SO
);

  localparam int TOTAL_WORDS = 1024*NUM_SER_BRAMS*NUM_PAR_BRAMS;
  localparam int IDX_W       = $clog2(TOTAL_WORDS+1);
  localparam int WAIT_W      = $clog2(CLEAR_WAIT);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(TOTAL_WORDS-1);
  localparam logic [IDX_W-1:0]  END_IDX   = IDX_W'(TOTAL_WORDS);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(CLEAR_WAIT-1);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR, WAIT_CLR} state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]  rd_idx_q;
  logic [IDX_W-1:0]  out_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              rd_pend_q;
  logic [31:0]       fifo_mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        fifo_cnt_q;

  logic       start_go;
  logic       xfer;
  logic       last_xfer;
  logic       issue;
  logic       flush;
  logic       wait_done;
  logic [1:0] occ_after_pop;

  assign start_go      = Start_SI | (AutoDrain_SI & LogFull_SI);
  assign OutValid_SO   = (fifo_cnt_q != 2'd0);
  assign xfer          = OutValid_SO & OutReady_SI;
  assign last_xfer     = xfer && (out_cnt_q == LAST_IDX);
  assign OutLast_SO    = OutValid_SO && (out_cnt_q == LAST_IDX);
  assign OutData_DO    = OutValid_SO ? fifo_mem_q[rd_ptr_q] : 32'd0;
  assign wait_done     = (state_q == WAIT_CLR) && (wait_cnt_q == '0);
  // Counting the word leaving this cycle as already gone keeps 1 word/cycle
  assign occ_after_pop = fifo_cnt_q - 2'(xfer);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: begin
        // First read goes out as we leave IDLE to hit the 2-cycle latency
        if (start_go) begin
          state_d = DRAIN;
          issue   = 1'b1;
        end
      end
      DRAIN: begin
        if (Abort_SI || last_xfer) begin
          state_d = CLEAR;
        end else begin
          issue = (rd_idx_q < END_IDX) &&
                  ((occ_after_pop + 2'(rd_pend_q)) < 2'd2);
        end
      end
      CLEAR:    state_d = WAIT_CLR;
      WAIT_CLR: if (wait_cnt_q == '0) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  assign flush       = (state_q == DRAIN) && (state_d != DRAIN);
  assign LogEn_SO    = (state_q == IDLE) || wait_done;
  assign LogClear_SO = (state_q == CLEAR);
  assign BramEn_SO   = issue;
  assign BramAddr_DO = issue ? (32'(rd_idx_q) << 2) : 32'd0;
  assign Busy_SO     = (state_q != IDLE);
  assign Done_SO     = wait_done;

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      rd_idx_q      <= '0;
      out_cnt_q     <= '0;
      rd_pend_q     <= 1'b0;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      fifo_cnt_q    <= 2'd0;
      fifo_mem_q[0] <= 32'd0;
      fifo_mem_q[1] <= 32'd0;
    end else if (flush) begin
      // Leaving DRAIN drops buffered words and any read still in flight
      rd_idx_q   <= '0;
      out_cnt_q  <= '0;
      rd_pend_q  <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      rd_pend_q <= issue;
      if (issue) rd_idx_q <= rd_idx_q + IDX_W'(1);
      if (rd_pend_q) begin
        fifo_mem_q[wr_ptr_q] <= BramRd_DI;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (xfer) begin
        rd_ptr_q  <= ~rd_ptr_q;
        out_cnt_q <= out_cnt_q + IDX_W'(1);
      end
      fifo_cnt_q <= fifo_cnt_q + 2'(rd_pend_q) - 2'(xfer);
    end
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      wait_cnt_q <= '0;
    end else if (state_q == CLEAR) begin
      wait_cnt_q <= WAIT_LOAD;
    end else if ((state_q == WAIT_CLR) && (wait_cnt_q != '0)) begin
      wait_cnt_q <= wait_cnt_q - WAIT_W'(1);
    end
  end

endmodule

// File: tb/tb_axi_bram_log_drain_ctrl.sv
// Self-checking bench for axi_bram_log_drain_ctrl; expected stream is the
// linear sequence of log words, compared against a BRAM model returning addr>>2 ^ salt.
module tb_axi_bram_log_drain_ctrl;

  localparam int NUM_SER = 1;
  localparam int NUM_PAR = 3;
  localparam int TOTAL   = 1024*NUM_SER*NUM_PAR;
  localparam int CW      = 1024*NUM_SER+4;

  logic        clk = 1'b0;
  logic        rst, start, auto_drain, abort, log_full, ready;
  logic        log_en, log_clear, bram_en, out_valid, out_last, busy, done;
  logic [31:0] bram_addr, out_data, salt;
  logic [31:0] bram_rd = 32'd0;

  int checks = 0;
  int errors = 0;

  axi_bram_log_drain_ctrl #(
    .NUM_SER_BRAMS(NUM_SER),
    .NUM_PAR_BRAMS(NUM_PAR)
  ) dut (
    .Clk_CI      (clk),
    .Rst_RI      (rst),
    .Start_SI    (start),
    .AutoDrain_SI(auto_drain),
    .Abort_SI    (abort),
    .LogFull_SI  (log_full),
    .LogEn_SO    (log_en),
    .LogClear_SO (log_clear),
    .BramEn_SO   (bram_en),
    .BramAddr_DO (bram_addr),
    .BramRd_DI   (bram_rd),
    .OutValid_SO (out_valid),
    .OutReady_SI (ready),
    .OutData_DO  (out_data),
    .OutLast_SO  (out_last),
    .Busy_SO     (busy),
    .Done_SO     (done)
  );

  always #5 clk = ~clk;

  // Logger BRAM port: registered read, one cycle latency
  always @(posedge clk) if (bram_en) bram_rd <= (bram_addr >> 2) ^ salt;

  // Counts cycles after the clear pulse until Done; -1 if it never arrives
  task automatic wait_done(output int done_at, output int clears, output logic en_at_done);
    done_at = -1; clears = 0; en_at_done = 1'b0;
    for (int d = 1; d <= CW + 20; d++) begin
      @(negedge clk); #1;
      if (log_clear) clears++;
      if (done) begin
        done_at = d; en_at_done = log_en;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int clears;
    rst = 1'b1; start = 1'b0; ready = 1'b1; salt = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({busy, log_en, out_valid, log_clear, done, bram_en, out_last} !== 7'b0100000) begin
      errors++; $display("[TB] FAIL reset_flags got=%b exp=0100000",
                         {busy, log_en, out_valid, log_clear, done, bram_en, out_last});
    end
    checks++;
    if (bram_addr !== 32'd0 || out_data !== 32'd0) begin
      errors++; $display("[TB] FAIL reset_buses addr=%h data=%h exp=0", bram_addr, out_data);
    end
    @(negedge clk); rst = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL mid_drain busy=%b valid=%b exp=1/1", busy, out_valid);
    end
    @(negedge clk); rst = 1'b1; #1;
    checks++;
    if ({busy, log_en, out_valid, log_clear} !== 4'b0100) begin
      errors++; $display("[TB] FAIL reset_mid_drain got=%b exp=0100",
                         {busy, log_en, out_valid, log_clear});
    end
    @(negedge clk); rst = 1'b0;
    clears = 0;
    repeat (20) begin
      @(negedge clk); #1;
      if (log_clear) clears++;
    end
    checks++;
    if (clears !== 0 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_no_clear clears=%0d busy=%b exp=0/0", clears, busy);
    end
  endtask

  task automatic test_full_drain();
    int k = 0, first_valid = -1, last_count = 0, clears, done_at;
    logic en_done;
    salt = 32'd0; ready = 1'b1;
    for (int cyc = 0; cyc < TOTAL + 100 && k < TOTAL; cyc++) begin
      @(negedge clk); start = (cyc == 0); #1;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_last) last_count++;
      if (cyc == 0) begin
        checks++;
        if (log_en !== 1'b1) begin errors++; $display("[TB] FAIL logen_start got=%b exp=1", log_en); end
      end
      if (cyc == 1) begin
        checks++;
        if (log_en !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("[TB] FAIL logen_drop logen=%b busy=%b exp=0/1", log_en, busy);
        end
      end
      if (out_valid && ready) begin
        checks++;
        if (out_data !== (32'(k) ^ salt) || out_last !== (k == TOTAL-1)) begin
          errors++; $display("[TB] FAIL full_word k=%0d got=%h/%b exp=%h/%b",
                             k, out_data, out_last, 32'(k) ^ salt, k == TOTAL-1);
        end
        k++;
      end
    end
    checks++;
    if (k !== TOTAL) begin errors++; $display("[TB] FAIL full_count got=%0d exp=%0d", k, TOTAL); end
    checks++;
    if (first_valid !== 2) begin errors++; $display("[TB] FAIL first_valid got=%0d exp=2", first_valid); end
    checks++;
    if (last_count !== 1) begin errors++; $display("[TB] FAIL last_count got=%0d exp=1", last_count); end
    @(negedge clk); #1;
    checks++;
    if (log_clear !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL clear_pulse clear=%b valid=%b exp=1/0", log_clear, out_valid);
    end
    wait_done(done_at, clears, en_done);
    checks++;
    if (done_at !== CW || clears !== 0 || en_done !== 1'b1) begin
      errors++; $display("[TB] FAIL full_done at=%0d clears=%0d logen=%b exp=%0d/0/1",
                         done_at, clears, en_done, CW);
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || log_en !== 1'b1 || done !== 1'b0) begin
      errors++; $display("[TB] FAIL full_idle busy=%b logen=%b done=%b exp=0/1/0", busy, log_en, done);
    end
  endtask

  task automatic test_backpressure();
    int k = 0, issued = 0, clears, done_at;
    logic en_done, prev_stall = 1'b0, prev_last = 1'b0;
    logic [31:0] prev_data = 32'd0;
    salt = $urandom;
    for (int cyc = 0; cyc < 20*TOTAL && k < TOTAL; cyc++) begin
      @(negedge clk); start = (cyc == 0); ready = ($urandom_range(0, 99) < 30); #1;
      if (bram_en) begin
        checks++;
        if (bram_addr !== 32'(issued*4)) begin
          errors++; $display("[TB] FAIL bp_addr n=%0d got=%h exp=%h", issued, bram_addr, 32'(issued*4));
        end
        issued++;
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
          errors++; $display("[TB] FAIL bp_stall_stable got=%b/%h/%b exp=1/%h/%b",
                             out_valid, out_data, out_last, prev_data, prev_last);
        end
      end
      if (out_valid && ready) begin
        checks++;
        if (out_data !== (32'(k) ^ salt) || out_last !== (k == TOTAL-1)) begin
          errors++; $display("[TB] FAIL bp_word k=%0d got=%h/%b exp=%h/%b",
                             k, out_data, out_last, 32'(k) ^ salt, k == TOTAL-1);
        end
        k++;
      end
      checks++;
      if (issued - k > 2) begin
        errors++; $display("[TB] FAIL bp_outstanding got=%0d exp<=2", issued - k);
      end
      prev_stall = out_valid && !ready; prev_data = out_data; prev_last = out_last;
    end
    checks++;
    if (k !== TOTAL || issued !== TOTAL) begin
      errors++; $display("[TB] FAIL bp_count words=%0d reads=%0d exp=%0d", k, issued, TOTAL);
    end
    ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (log_clear !== 1'b1) begin errors++; $display("[TB] FAIL bp_clear got=%b exp=1", log_clear); end
    wait_done(done_at, clears, en_done);
    checks++;
    if (done_at !== CW || clears !== 0) begin
      errors++; $display("[TB] FAIL bp_done at=%0d clears=%0d exp=%0d/0", done_at, clears, CW);
    end
  endtask

  task automatic test_abort();
    int k = 0, clears, done_at;
    logic en_done;
    salt = $urandom;
    for (int cyc = 0; cyc < 400 && k < 100; cyc++) begin
      @(negedge clk); start = (cyc == 0); ready = 1'b1; #1;
      if (out_valid && ready) begin
        checks++;
        if (out_data !== (32'(k) ^ salt)) begin
          errors++; $display("[TB] FAIL abort_word k=%0d got=%h exp=%h", k, out_data, 32'(k) ^ salt);
        end
        k++;
      end
    end
    @(negedge clk); ready = 1'b0; abort = 1'b1; #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== (32'd100 ^ salt)) begin
      errors++; $display("[TB] FAIL abort_head valid=%b data=%h exp=1/%h", out_valid, out_data, 32'd100 ^ salt);
    end
    @(negedge clk); abort = 1'b0; #1;
    checks++;
    if (out_valid !== 1'b0 || log_clear !== 1'b1 || bram_en !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_next valid=%b clear=%b en=%b exp=0/1/0", out_valid, log_clear, bram_en);
    end
    ready = 1'b1;
    wait_done(done_at, clears, en_done);
    checks++;
    if (done_at !== CW || clears !== 0 || en_done !== 1'b1) begin
      errors++; $display("[TB] FAIL abort_done at=%0d clears=%0d logen=%b exp=%0d/0/1",
                         done_at, clears, en_done, CW);
    end
  endtask

  task automatic test_auto_trigger();
    int clears, done_at;
    logic en_done;
    auto_drain = 1'b0; log_full = 1'b1; ready = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || log_en !== 1'b1) begin
      errors++; $display("[TB] FAIL auto_off_idle busy=%b logen=%b exp=0/1", busy, log_en);
    end
    @(negedge clk); auto_drain = 1'b1;
    @(negedge clk); auto_drain = 1'b0; log_full = 1'b0; #1;
    checks++;
    if (busy !== 1'b1 || log_en !== 1'b0) begin
      errors++; $display("[TB] FAIL auto_start busy=%b logen=%b exp=1/0", busy, log_en);
    end
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0; #1;
    checks++;
    if (log_clear !== 1'b1) begin errors++; $display("[TB] FAIL auto_clear got=%b exp=1", log_clear); end
    wait_done(done_at, clears, en_done);
    checks++;
    if (done_at !== CW) begin errors++; $display("[TB] FAIL auto_done at=%0d exp=%0d", done_at, CW); end
  endtask

  task automatic test_back_to_back();
    int k = 0, clears, done_at;
    logic en_done;
    salt = $urandom;
    for (int cyc = 0; cyc < TOTAL + 100 && k < TOTAL; cyc++) begin
      @(negedge clk); start = 1'b1; abort = (cyc == 0) || (k == TOTAL-1); ready = 1'b1; #1;
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL start_beats_abort busy=%b exp=1", busy); end
      end
      if (out_valid && ready) begin
        checks++;
        if (out_data !== (32'(k) ^ salt) || out_last !== (k == TOTAL-1)) begin
          errors++; $display("[TB] FAIL b2b_word k=%0d got=%h/%b exp=%h/%b",
                             k, out_data, out_last, 32'(k) ^ salt, k == TOTAL-1);
        end
        k++;
      end
    end
    checks++;
    if (k !== TOTAL) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=%0d", k, TOTAL); end
    @(negedge clk); abort = 1'b0; #1;
    checks++;
    if (log_clear !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_clear clear=%b valid=%b exp=1/0", log_clear, out_valid);
    end
    wait_done(done_at, clears, en_done);
    checks++;
    if (done_at !== CW || clears !== 0) begin
      errors++; $display("[TB] FAIL b2b_done at=%0d clears=%0d exp=%0d/0", done_at, clears, CW);
    end
    @(negedge clk); start = 1'b0; #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle busy=%b exp=0", busy); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; auto_drain = 1'b0; abort = 1'b0;
    log_full = 1'b0; ready = 1'b1; salt = 32'd0;
    test_reset();
    test_full_drain();
    test_backpressure();
    test_abort();
    test_auto_trigger();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
